// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory arbiter:
//               FSM state encoding and the default data_mem geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

  // Default data_mem geometry, also used by the data_mem instance.
  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 32;

  // Width of the starvation counter; covers MAX_WAIT up to 255.
  localparam int WAIT_W = 8;

  // Arbiter states; the unused code 2'd3 falls back to IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DBG_ACC = 2'd1,
    DBG_RSP = 2'd2
  } arb_state_t;

  // The MEM stage wants the memory port when it loads or stores.
  function automatic logic cpu_access(input logic wmem, input logic m2reg);
    return wmem | m2reg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bus bundle around the data-memory arbiter: MEM-stage request,
//               debug/loader handshake and the data_mem port.
//               slave  = arbiter view, master = surrounding pipeline/memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW
);

  // MEM-stage side
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_wmem;
  logic          cpu_m2reg;
  logic          cpu_stall;

  // Debug/loader side
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;

  // data_mem side
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_wmem, cpu_m2reg,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_stall, dbg_ack, dbg_rdata,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_wmem, cpu_m2reg,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_stall, dbg_ack, dbg_rdata,
    input  mem_addr, mem_wdata, mem_we
  );

endinterface
`default_nettype wire

// File: rtl/dmem_arb_wait_cnt.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_wait_cnt
// Description : Saturating debug starvation counter. Counts cycles a debug
//               request has been held off by CPU traffic; at_limit forces the
//               grant. Never counts past MAX_WAIT.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_wait_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt;

  // Clear wins over increment; increment stops once the limit is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + WAIT_W'(1);
    end
  end

  assign at_limit = (cnt == LIMIT);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port data memory between the MEM stage and
//               a debug/loader port. The CPU has priority; debug is granted
//               on idle memory cycles or, after MAX_WAIT cycles of contention,
//               by stalling the pipeline for exactly one cycle. The stalled
//               CPU access re-executes in the following (response) cycle.
//               Optional macro DMEM_ARB_STATS_EN enables the stall counter;
//               otherwise stall_cnt reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = DMEM_AW,
  parameter int DW       = DMEM_DW,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_arbiter_if.slave    bus,
  output logic [15:0]      stall_cnt
);

  arb_state_t    state;
  arb_state_t    state_nxt;

  logic          cpu_req;
  logic          grant;
  logic          wait_inc;
  logic          wait_clr;
  logic          at_limit;

  // Debug request captured at grant so the memory mux never looks at dbg_*.
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

  logic [AW-1:0] mux_addr;
  logic [DW-1:0] mux_wdata;
  logic          mux_we;
  logic          stall;
  logic          ack;
  logic [DW-1:0] rdata;

  assign cpu_req  = cpu_access(bus.cpu_wmem, bus.cpu_m2reg);
  assign grant    = (state == IDLE) && bus.dbg_req && (!cpu_req || at_limit);
  assign wait_inc = (state == IDLE) && bus.dbg_req && cpu_req && !grant;
  assign wait_clr = grant || ((state == IDLE) && !bus.dbg_req);

  dmem_arb_wait_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (wait_inc),
    .clr      (wait_clr),
    .at_limit (at_limit)
  );

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the debug transaction on the grant edge for use in DBG_ACC/DBG_RSP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_we    <= 1'b0;
      acc_addr  <= '0;
      acc_wdata <= '0;
    end else if (grant) begin
      acc_we    <= bus.dbg_we;
      acc_addr  <= bus.dbg_addr;
      acc_wdata <= bus.dbg_wdata;
    end
  end

  // Next state and port mux: CPU owns the port except during DBG_ACC.
  always_comb begin
    state_nxt = IDLE;
    mux_addr  = bus.cpu_addr;
    mux_wdata = bus.cpu_wdata;
    mux_we    = bus.cpu_wmem;
    stall     = 1'b0;
    ack       = 1'b0;
    rdata     = '0;
    case (state)
      IDLE: begin
        state_nxt = grant ? DBG_ACC : IDLE;
      end
      DBG_ACC: begin
        state_nxt = DBG_RSP;
        mux_addr  = acc_addr;
        mux_wdata = acc_wdata;
        mux_we    = acc_we;
        stall     = cpu_req;
      end
      DBG_RSP: begin
        state_nxt = IDLE;
        ack       = 1'b1;
        rdata     = acc_we ? '0 : bus.mem_rdata;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.mem_addr  = mux_addr;
  assign bus.mem_wdata = mux_wdata;
  // Write enable drops the instant reset asserts, even mid-access.
  assign bus.mem_we    = mux_we & rst_n;
  assign bus.cpu_stall = stall;
  assign bus.dbg_ack   = ack;
  assign bus.dbg_rdata = rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of pipeline stall cycles; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (stall && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a behavioural
//               registered-read data memory and a scoreboard queue of
//               expected read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;

`ifdef DMEM_ARB_STATS_EN
  localparam logic [15:0] EXP_STALLS = 16'd3;
`else
  localparam logic [15:0] EXP_STALLS = 16'd0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   stall_cnt;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_q   [$];

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural data_mem: synchronous write, registered read.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [DW-1:0] obs);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, obs);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic probe();
    #2;
  endtask

  task automatic cpu_idle();
    bus.cpu_wmem  = 1'b0;
    bus.cpu_m2reg = 1'b0;
  endtask

  // Two-cycle CPU load of addr checked against the reference memory.
  task automatic cpu_load_check(input logic [AW-1:0] a, input string tag);
    go();
    cpu_idle();
    bus.dbg_req   = 1'b0;
    bus.cpu_m2reg = 1'b1;
    bus.cpu_addr  = a;
    exp_q.push_back(ref_mem[a]);
    probe();
    go();
    cpu_idle();
    probe();
    pop_check(tag, bus.mem_rdata);
  endtask

  // Debug read of addr under continuous CPU loads; grant is forced by starvation.
  task automatic forced_read(input logic [AW-1:0] a, input string tag);
    logic [AW-1:0] ca;
    go();
    ca            = 8'h30;
    bus.cpu_m2reg = 1'b1;
    bus.cpu_addr  = ca;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = a;
    exp_q.push_back(ref_mem[a]);
    probe();
    check({tag, "_stall_k0"}, bus.cpu_stall, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      go();
      if (k == 7) bus.dbg_req = 1'b0;
      ca           = ca + 8'd1;
      bus.cpu_addr = ca;
      probe();
      check($sformatf("%s_stall_k%0d", tag, k), bus.cpu_stall, (k == MAX_WAIT + 1));
      check($sformatf("%s_ack_k%0d", tag, k), bus.dbg_ack, (k == MAX_WAIT + 2));
      if (k == MAX_WAIT + 1) check({tag, "_acc_addr"}, bus.mem_addr, a);
      if (k == MAX_WAIT + 2) pop_check({tag, "_rdata"}, bus.dbg_rdata);
    end
    cpu_idle();
  endtask

  initial begin
    logic [AW-1:0] a;

    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = {24'hA50000, 8'(i)};
      ref_mem[i] = {24'hA50000, 8'(i)};
    end

    // Reset with a CPU store and a debug request pending: nothing may escape.
    rst_n          = 1'b0;
    bus.cpu_addr   = 8'hFF;
    bus.cpu_wdata  = 32'h0;
    bus.cpu_wmem   = 1'b1;
    bus.cpu_m2reg  = 1'b0;
    bus.dbg_req    = 1'b1;
    bus.dbg_we     = 1'b1;
    bus.dbg_addr   = 8'hFE;
    bus.dbg_wdata  = 32'h0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_cpu_stall", bus.cpu_stall, 1'b0);
    check("rst_dbg_ack", bus.dbg_ack, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_dbg_rdata", bus.dbg_rdata, '0);
    check("rst_stall_cnt", stall_cnt, '0);
    go();
    rst_n = 1'b1;
    cpu_idle();
    bus.dbg_req = 1'b0;
    probe();
    cpu_load_check(8'hFF, "rst_no_write_ff");

    // Debug write with the CPU idle: access in t+1, ack in t+2, no stall.
    go();
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 8'h10;
    bus.dbg_wdata = 32'hDEADBEEF;
    probe();
    check("dw_k0_mem_we", bus.mem_we, 1'b0);
    go();
    probe();
    check("dw_k1_mem_we", bus.mem_we, 1'b1);
    check("dw_k1_mem_addr", bus.mem_addr, 8'h10);
    check("dw_k1_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("dw_k1_stall", bus.cpu_stall, 1'b0);
    check("dw_k1_ack", bus.dbg_ack, 1'b0);
    go();
    probe();
    check("dw_k2_ack", bus.dbg_ack, 1'b1);
    check("dw_k2_rdata", bus.dbg_rdata, '0);
    check("dw_k2_stall", bus.cpu_stall, 1'b0);
    ref_mem[8'h10] = 32'hDEADBEEF;
    cpu_load_check(8'h10, "dw_cpu_load");

    // Reset during DBG_ACC: write enable drops at once, no ack follows.
    go();
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 8'h60;
    bus.dbg_wdata = 32'h0BAD0BAD;
    probe();
    go();
    probe();
    check("ra_acc_mem_we", bus.mem_we, 1'b1);
    rst_n       = 1'b0;
    bus.dbg_req = 1'b0;
    #1;
    check("ra_rst_mem_we", bus.mem_we, 1'b0);
    check("ra_rst_ack", bus.dbg_ack, 1'b0);
    go();
    rst_n = 1'b1;
    probe();
    check("ra_after_ack", bus.dbg_ack, 1'b0);
    check("ra_after_mem_we", bus.mem_we, 1'b0);
    cpu_load_check(8'h60, "ra_no_write_60");
    go();
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 8'h60;
    bus.dbg_wdata = 32'h0600D000;
    probe();
    go();
    probe();
    check("ra_reissue_we", bus.mem_we, 1'b1);
    check("ra_reissue_wdata", bus.mem_wdata, 32'h0600D000);
    go();
    probe();
    check("ra_reissue_ack", bus.dbg_ack, 1'b1);
    ref_mem[8'h60] = 32'h0600D000;
    cpu_load_check(8'h60, "ra_reissue_load");

    // Debug read starved by continuous CPU loads.
    forced_read(8'h20, "fr1");

    // Back-to-back debug reads of 0..3; CPU stores issued in the ack cycles.
    for (int c = 0; c < 12; c++) begin
      go();
      cpu_idle();
      if (c % 3 == 0) begin
        a            = AW'(c / 3);
        bus.dbg_req  = 1'b1;
        bus.dbg_we   = 1'b0;
        bus.dbg_addr = a;
        exp_q.push_back(ref_mem[a]);
      end
      if (c % 3 == 2) begin
        a             = 8'h40 + AW'(c / 3);
        bus.cpu_wmem  = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = 32'h57000000 + DW'(c / 3);
        ref_mem[a]    = 32'h57000000 + DW'(c / 3);
      end
      probe();
      check($sformatf("b2b_ack_c%0d", c), bus.dbg_ack, (c % 3 == 2));
      check($sformatf("b2b_stall_c%0d", c), bus.cpu_stall, 1'b0);
      if (c % 3 == 2) pop_check($sformatf("b2b_rdata_c%0d", c), bus.dbg_rdata);
    end
    for (int i = 0; i < 4; i++) begin
      cpu_load_check(8'h40 + AW'(i), $sformatf("b2b_store_%0d", i));
    end

    // CPU store and forced debug write to the same address: CPU data lands last.
    go();
    bus.cpu_wmem  = 1'b1;
    bus.cpu_addr  = 8'h50;
    bus.cpu_wdata = 32'hCAFE0001;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 8'h50;
    bus.dbg_wdata = 32'h11111111;
    probe();
    for (int k = 1; k <= MAX_WAIT + 2; k++) begin
      go();
      probe();
      if (k == MAX_WAIT + 1) begin
        check("col_acc_stall", bus.cpu_stall, 1'b1);
        check("col_acc_wdata", bus.mem_wdata, 32'h11111111);
        check("col_acc_we", bus.mem_we, 1'b1);
      end
      if (k == MAX_WAIT + 2) begin
        check("col_rsp_ack", bus.dbg_ack, 1'b1);
        check("col_rsp_wdata", bus.mem_wdata, 32'hCAFE0001);
        check("col_rsp_we", bus.mem_we, 1'b1);
      end
    end
    ref_mem[8'h50] = 32'hCAFE0001;
    cpu_load_check(8'h50, "col_final");

    // Third forced grant, then the stall statistics.
    forced_read(8'h21, "fr2");
    go();
    probe();
    check("stall_cnt", stall_cnt, EXP_STALLS);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the pipeline's MEM stage and a debug/loader port. The CPU has default priority and passes straight through; debug requests are served in idle memory cycles or, after a bounded wait, by stalling the pipeline for one cycle. The block sits between the EX/MEM register outputs (address, write data, write enable, load flag) and the `data_mem` instance, and drives the pipeline stall input.

## Interface
- `AW`, 8: memory address width (word addresses).
- `DW`, 32: data width.
- `MAX_WAIT`, 4: debug starvation limit in cycles; legal range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cpu_addr` in AW: MEM-stage address (ALU result low bits).
- `cpu_wdata` in DW: MEM-stage store data.
- `cpu_wmem` in 1: MEM-stage store.
- `cpu_m2reg` in 1: MEM-stage load.
- `cpu_stall` out 1: hold the EX/MEM register and all upstream stages this cycle.
- `dbg_req` in 1: debug transaction request; level-held until `dbg_ack`.
- `dbg_we` in 1: debug write (1) or read (0); stable while `dbg_req` is high.
- `dbg_addr` in AW: debug address; stable while `dbg_req` is high.
- `dbg_wdata` in DW: debug write data; stable while `dbg_req` is high.
- `dbg_ack` out 1: one-cycle completion pulse.
- `dbg_rdata` out DW: read data; valid only while `dbg_ack` is high.
- `mem_addr` out AW: address to `data_mem`.
- `mem_wdata` out DW: write data to `data_mem`.
- `mem_we` out 1: write enable to `data_mem`.
- `mem_rdata` in DW: `data_mem` output. Read data is registered, so it is valid one cycle after the address is presented.
- `stall_cnt` out 16: saturating count of stall cycles (see Configuration).

## Operation
- CPU request: `cpu_req = cpu_wmem | cpu_m2reg`.
- FSM states:
  - IDLE: CPU drives the memory port combinationally (`mem_we = cpu_wmem`).
  - DBG_ACC: debug drives the port (`mem_we = dbg_we`). `cpu_stall = cpu_req`.
  - DBG_RSP: CPU drives the port. `dbg_ack = 1`. `dbg_rdata = mem_rdata` for reads, 0 for writes.
- IDLE to DBG_ACC when `dbg_req & (~cpu_req | wait_cnt == MAX_WAIT)`.
- DBG_ACC always moves to DBG_RSP. DBG_RSP always moves to IDLE.
- `wait_cnt` behaviour:
  - Increments in IDLE while `dbg_req & cpu_req` and the grant is not taken.
  - Clears on entry to DBG_ACC.
  - Also clears in IDLE whenever `dbg_req` is low.
  - Never exceeds `MAX_WAIT`.
- `dbg_req` is ignored in DBG_ACC and DBG_RSP. If it is still high in the cycle after the ack, it is a new transaction (back-to-back allowed; minimum 3 cycles per transaction).
- A CPU access is never dropped. In DBG_ACC the stalled CPU access re-executes in DBG_RSP.
- Reset values:
  - state = IDLE, `wait_cnt` = 0, `stall_cnt` = 0.
  - `cpu_stall`, `dbg_ack`, `mem_we` = 0.
  - `dbg_rdata` = 0.
- Reset mid-transaction aborts it with no ack and no further write. The requester must re-issue.

## Timing
- Debug latency with the memory idle: request sampled at edge t, memory access in cycle t+1, `dbg_ack` in cycle t+2.
- Debug latency with continuous CPU traffic: ack arrives `MAX_WAIT + 2` cycles after the first sampled request.
- `cpu_stall` is asserted for at most 1 cycle per debug transaction.
- `cpu_stall` and the memory mux depend combinationally on state and CPU inputs only, never on `dbg_*` inputs.
- CPU path latency is unchanged (zero added cycles) in IDLE and DBG_RSP.

## Configuration
- `DMEM_ARB_STATS_EN` defined:
  - `stall_cnt` increments on every cycle with `cpu_stall = 1`.
  - It saturates at 16'hFFFF and clears only on reset.
- Not defined: `stall_cnt` is tied to 0 and the counter logic is absent. The port remains present in both builds.

## Structure
- Shared package `dmem_arb_pkg` holds:
  - The FSM state encoding (IDLE=2'd0, DBG_ACC=2'd1, DBG_RSP=2'd2; 2'd3 recovers to IDLE).
  - Default AW/DW constants, shared with `data_mem`.
- One sub-module, `dmem_arb_wait_cnt`: the saturating starvation counter with inc/clr/at_limit ports.

## Test plan
- Debug write, CPU idle: `dbg_we=1`, addr 8'h10, data 32'hDEADBEEF -> `mem_we` high in cycle t+1, ack in t+2, `cpu_stall` never high; a later CPU load from 8'h10 returns 32'hDEADBEEF.
- Debug read under continuous CPU loads, `MAX_WAIT=4` -> `cpu_stall` is high for exactly 1 cycle, 5 cycles after the request; ack 6 cycles after the request; `dbg_rdata` equals the preloaded word.
- Back-to-back debug reads of 8'h00..8'h03 with `dbg_req` held high -> acks every 3 cycles with the correct data; CPU stores interleaved in between all land.
- Simultaneous CPU store and forced debug write to the same address -> debug writes in DBG_ACC, the stalled CPU store re-executes in DBG_RSP; final value is the CPU data.
- `rst_n` low during DBG_ACC -> no ack, `mem_we=0` immediately, state IDLE; a re-issued request completes normally.
- With `DMEM_ARB_STATS_EN`, after 3 forced grants `stall_cnt == 3`; without the macro it reads 0.
